// File: rtl/uart_display_ctrl.sv
//============================================================================
// Module   : uart_display_ctrl
// Brief    : Framed-command parser driving a two-digit display byte/blank flag.
//            Define FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT_CLKS.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module uart_display_ctrl #(
    parameter int         MAX_LEN      = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic [7:0] o_Disp_Byte,
    output logic       o_Disp_Blank,
    output logic       o_Disp_Upd,
    output logic       o_Frame_Err,
    output logic [7:0] o_Err_Count,
    output logic       o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_EXEC    = 3'd4
    } state_t;

    localparam logic [7:0] c_CMD_SET   = 8'h01;
    localparam logic [7:0] c_CMD_BLANK = 8'h02;
    localparam logic [7:0] c_CMD_INC   = 8'h03;
    localparam logic [7:0] c_MAX_LEN   = 8'(MAX_LEN);

    state_t     r_state;
    logic [3:0] r_len;
    logic [3:0] r_cnt;
    logic [7:0] r_chk;
    logic [7:0] r_buf [MAX_LEN];
    logic [7:0] w_set_byte;

    generate
        if (MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_CLKS < 2) begin : g_bad_param
            $error("uart_display_ctrl: MAX_LEN must be 1..15 and TIMEOUT_CLKS >= 2");
        end
    endgenerate

    // A one-byte buffer can never hold a SET operand; SET then fails its length check.
    generate
        if (MAX_LEN > 1) begin : g_set_operand
            assign w_set_byte = r_buf[1];
        end else begin : g_no_set_operand
            assign w_set_byte = 8'h00;
        end
    endgenerate

`ifdef FRAME_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CLKS - 1);
    logic [c_TO_W-1:0] r_to_cnt;
`endif

    function automatic logic [7:0] inc_sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign o_Busy = (r_state != S_IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state      <= S_IDLE;
            r_len        <= 4'd0;
            r_cnt        <= 4'd0;
            r_chk        <= 8'h00;
            for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
            o_Disp_Byte  <= 8'h00;
            o_Disp_Blank <= 1'b1;
            o_Disp_Upd   <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Err_Count  <= 8'h00;
`ifdef FRAME_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            o_Disp_Upd  <= 1'b0;
            o_Frame_Err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_RX_DV && i_RX_Byte == SYNC_BYTE) r_state <= S_LEN;
                end
                S_LEN: begin
                    if (i_RX_DV) begin
                        if (i_RX_Byte == 8'h00 || i_RX_Byte > c_MAX_LEN) begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Count <= inc_sat(o_Err_Count);
                            r_state     <= S_IDLE;
                        end else begin
                            r_len   <= i_RX_Byte[3:0];
                            r_cnt   <= 4'd0;
                            r_chk   <= i_RX_Byte;
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (i_RX_DV) begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (r_cnt == 4'(i)) r_buf[i] <= i_RX_Byte;
                        r_chk <= r_chk ^ i_RX_Byte;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == r_len - 4'd1) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (i_RX_DV) begin
                        if (i_RX_Byte != r_chk) begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Count <= inc_sat(o_Err_Count);
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // Any byte strobed here is dropped: the UART cannot deliver one this soon.
                    r_state <= S_IDLE;
                    if (r_buf[0] == c_CMD_SET && r_len == 4'd2) begin
                        o_Disp_Byte  <= w_set_byte;
                        o_Disp_Blank <= 1'b0;
                        o_Disp_Upd   <= 1'b1;
                    end else if (r_buf[0] == c_CMD_BLANK && r_len == 4'd1) begin
                        o_Disp_Blank <= 1'b1;
                        o_Disp_Upd   <= 1'b1;
                    end else if (r_buf[0] == c_CMD_INC && r_len == 4'd1) begin
                        o_Disp_Byte  <= o_Disp_Byte + 8'd1;
                        o_Disp_Blank <= 1'b0;
                        o_Disp_Upd   <= 1'b1;
                    end else begin
                        o_Frame_Err <= 1'b1;
                        o_Err_Count <= inc_sat(o_Err_Count);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

`ifdef FRAME_TIMEOUT_EN
            // A timeout only fires on a cycle with no byte, so it never collides with the case above.
            if (i_RX_DV || r_state == S_IDLE || r_state == S_EXEC) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == c_TO_LAST) begin
                r_to_cnt    <= '0;
                r_state     <= S_IDLE;
                o_Frame_Err <= 1'b1;
                o_Err_Count <= inc_sat(o_Err_Count);
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

`default_nettype wire
